// File: rtl/decode_stage.sv
// decode_stage: IF/ID pipeline register and decode stage of a 5-stage MIPS pipeline.
//   Latches fe_pc/fe_instr from fetch and decodes them against the register file
//   (rf_ra*/rf_rd*), with forwarding from MEM (mem_*) and WB (wb_*).
//   Load-use and branch-operand hazards against EX (ex_*) and MEM raise stall to fetch.
//   Branch/jr operands go back to fetch: eq, vs, prev, prev_pc.
//   id_* is the registered bundle to EX; ex_hold freezes the whole stage.
//   stall_cycles is a saturating count of cycles stalled on hazards.
module decode_stage #(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            fe_pc,
    input  logic [31:0]            fe_instr,
    input  logic                   ex_hold,
    output logic                   stall,
    output logic                   eq,
    output logic [31:0]            vs,
    output logic [31:0]            prev,
    output logic [31:0]            prev_pc,
    output logic [4:0]             rf_ra1,
    output logic [4:0]             rf_ra2,
    input  logic [31:0]            rf_rd1,
    input  logic [31:0]            rf_rd2,
    input  logic                   ex_wen,
    input  logic                   ex_load,
    input  logic [4:0]             ex_wreg,
    input  logic                   mem_wen,
    input  logic                   mem_load,
    input  logic [4:0]             mem_wreg,
    input  logic [31:0]            mem_result,
    input  logic                   wb_wen,
    input  logic [4:0]             wb_wreg,
    input  logic [31:0]            wb_result,
    output logic                   id_valid,
    output logic [31:0]            id_pc,
    output logic [31:0]            id_instr,
    output logic [31:0]            id_a,
    output logic [31:0]            id_b,
    output logic [31:0]            id_imm,
    output logic [4:0]             id_wreg,
    output logic                   id_wen,
    output logic                   id_load,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    typedef enum logic {RUN, HAZ} state_t;

    state_t                 r_state, w_state_nx;
    logic [31:0]            r_pc, r_instr;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic [5:0]             w_op;
    logic [4:0]             w_rs, w_rt, w_rd, w_dst;
    logic                   w_rtype, w_jr, w_immalu, w_lui, w_lw, w_sw, w_beq, w_bne, w_jal;
    logic                   w_use_rs, w_use_rt, w_br, w_hazard;
    logic [31:0]            w_a, w_b, w_imm;

    // A source depends on a producer only when it is actually read and is not $0.
    function automatic logic dep(input logic use_src, input logic [4:0] src,
                                 input logic en, input logic [4:0] dst);
        return use_src && src != 5'd0 && en && src == dst;
    endfunction

    assign w_op     = r_instr[31:26];
    assign w_rs     = r_instr[25:21];
    assign w_rt     = r_instr[20:16];
    assign w_rd     = r_instr[15:11];
    assign w_rtype  = w_op == 6'h00;
    assign w_jr     = w_rtype && r_instr[5:0] == 6'h08;
    assign w_immalu = w_op == 6'h08 || w_op == 6'h09 || w_op == 6'h0a || w_op == 6'h0c || w_op == 6'h0d;
    assign w_lui    = w_op == 6'h0f;
    assign w_lw     = w_op == 6'h23;
    assign w_sw     = w_op == 6'h2b;
    assign w_beq    = w_op == 6'h04;
    assign w_bne    = w_op == 6'h05;
    assign w_jal    = w_op == 6'h03;
    assign w_use_rs = w_rtype || w_immalu || w_lw || w_sw || w_beq || w_bne;
    assign w_use_rt = (w_rtype && !w_jr) || w_sw || w_beq || w_bne;
    assign w_br     = w_beq || w_bne || w_jr;
    // Unknown opcodes fall through to no destination, i.e. behave as a nop.
    assign w_dst    = (w_rtype && !w_jr) ? w_rd :
                      (w_immalu || w_lui || w_lw) ? w_rt :
                      w_jal ? 5'd31 : 5'd0;
    assign w_imm    = (w_op == 6'h0c || w_op == 6'h0d) ? {16'h0, r_instr[15:0]} :
                      w_lui ? {r_instr[15:0], 16'h0} :
                      {{16{r_instr[15]}}, r_instr[15:0]};

    // A load in MEM has no data yet, so it is never a forwarding source.
    assign w_a = w_rs == 5'd0 ? 32'h0 :
                 (mem_wen && !mem_load && mem_wreg == w_rs) ? mem_result :
                 (wb_wen && wb_wreg == w_rs) ? wb_result : rf_rd1;
    assign w_b = w_rt == 5'd0 ? 32'h0 :
                 (mem_wen && !mem_load && mem_wreg == w_rt) ? mem_result :
                 (wb_wen && wb_wreg == w_rt) ? wb_result : rf_rd2;

    // Branches resolve in ID, so they also wait on any EX result and on a MEM load.
    assign w_hazard = dep(w_use_rs, w_rs, ex_wen && ex_load, ex_wreg) ||
                      dep(w_use_rt, w_rt, ex_wen && ex_load, ex_wreg) ||
                      dep(w_br && w_use_rs, w_rs, ex_wen, ex_wreg) ||
                      dep(w_br && w_use_rt, w_rt, ex_wen, ex_wreg) ||
                      dep(w_br && w_use_rs, w_rs, mem_wen && mem_load, mem_wreg) ||
                      dep(w_br && w_use_rt, w_rt, mem_wen && mem_load, mem_wreg);

    assign stall        = w_hazard && !ex_hold;
    assign eq           = w_a == w_b;
    assign vs           = w_a;
    assign prev         = w_hazard ? 32'h0 : r_instr;
    assign prev_pc      = r_pc;
    assign rf_ra1       = w_rs;
    assign rf_ra2       = w_rt;
    assign stall_cycles = r_stall_cnt;

    // The state only records whether ID is hazard-stalled; no output depends on it.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            RUN:     w_state_nx = w_hazard ? HAZ : RUN;
            HAZ:     w_state_nx = w_hazard ? HAZ : RUN;
            default: w_state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_pc        <= 32'h0;
            r_instr     <= 32'h0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nx;
            if (!w_hazard && !ex_hold) begin
                r_pc    <= fe_pc;
                r_instr <= fe_instr;
            end
            if (stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid <= 1'b0;
            id_pc    <= 32'h0;
            id_instr <= 32'h0;
            id_a     <= 32'h0;
            id_b     <= 32'h0;
            id_imm   <= 32'h0;
            id_wreg  <= 5'd0;
            id_wen   <= 1'b0;
            id_load  <= 1'b0;
        end else if (!ex_hold) begin
            id_pc    <= r_pc;
            id_a     <= w_a;
            id_b     <= w_b;
            id_imm   <= w_imm;
            id_valid <= !w_hazard && r_instr != 32'h0;
            id_instr <= w_hazard ? 32'h0 : r_instr;
            id_wreg  <= w_hazard ? 5'd0 : w_dst;
            id_wen   <= !w_hazard && w_dst != 5'd0;
            id_load  <= !w_hazard && w_lw && w_dst != 5'd0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage (table vectors plus pipeline corner sequences).
module tb_decode_stage;
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  wreg;
        logic        wen;
        logic        load;
    } bun_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        mwen;
        logic        mload;
        logic [4:0]  mwreg;
        logic [31:0] mres;
        logic        wwen;
        logic [4:0]  wwreg;
        logic [31:0] wres;
        bun_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fe_pc, fe_instr;
    logic        ex_hold;
    logic        stall, eq;
    logic [31:0] vs, prev, prev_pc;
    logic [4:0]  rf_ra1, rf_ra2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        ex_wen, ex_load;
    logic [4:0]  ex_wreg;
    logic        mem_wen, mem_load;
    logic [4:0]  mem_wreg;
    logic [31:0] mem_result;
    logic        wb_wen;
    logic [4:0]  wb_wreg;
    logic [31:0] wb_result;
    logic        id_valid;
    logic [31:0] id_pc, id_instr, id_a, id_b, id_imm;
    logic [4:0]  id_wreg;
    logic        id_wen, id_load;
    logic [3:0]  stall_cycles;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_cnt;
    bun_t       sb[$];
    vec_t       vecs[17];
    bun_t       beq_bun;

    always #5 clk = ~clk;

    decode_stage #(.STALL_CNT_W(4)) dut (
        .clk(clk), .reset(reset), .fe_pc(fe_pc), .fe_instr(fe_instr), .ex_hold(ex_hold),
        .stall(stall), .eq(eq), .vs(vs), .prev(prev), .prev_pc(prev_pc),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .ex_wen(ex_wen), .ex_load(ex_load), .ex_wreg(ex_wreg),
        .mem_wen(mem_wen), .mem_load(mem_load), .mem_wreg(mem_wreg), .mem_result(mem_result),
        .wb_wen(wb_wen), .wb_wreg(wb_wreg), .wb_result(wb_result),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_a(id_a), .id_b(id_b),
        .id_imm(id_imm), .id_wreg(id_wreg), .id_wen(id_wen), .id_load(id_load),
        .stall_cycles(stall_cycles)
    );

    function automatic bun_t act_bun();
        return {id_valid, id_pc, id_instr, id_a, id_b, id_imm, id_wreg, id_wen, id_load};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, pc, rd1, rd2,
                                input logic mwen, mload, input logic [4:0] mwreg, input logic [31:0] mres,
                                input logic wwen, input logic [4:0] wwreg, input logic [31:0] wres,
                                input logic ev, input logic [31:0] ea, eb, eimm,
                                input logic [4:0] ewreg, input logic ewen, eload);
        vec_t t;
        t.instr = instr; t.pc = pc; t.rd1 = rd1; t.rd2 = rd2;
        t.mwen = mwen; t.mload = mload; t.mwreg = mwreg; t.mres = mres;
        t.wwen = wwen; t.wwreg = wwreg; t.wres = wres;
        t.exp = {ev, pc, instr, ea, eb, eimm, ewreg, ewen, eload};
        return t;
    endfunction

    task automatic chk(input string name, input logic [167:0] act, input logic [167:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        ex_hold = 0; ex_wen = 0; ex_load = 0; ex_wreg = 0;
        mem_wen = 0; mem_load = 0; mem_wreg = 0; mem_result = 0;
        wb_wen = 0; wb_wreg = 0; wb_result = 0; rf_rd1 = 0; rf_rd2 = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic cnt_inc();
        exp_cnt = (exp_cnt == 4'hF) ? exp_cnt : exp_cnt + 4'd1;
    endtask

    initial begin
        clr();
        reset = 1; fe_pc = 0; fe_instr = 0;
        step(); step();
        reset = 0;
        exp_cnt = 0;
        chk("reset_bundle", act_bun(), 168'h0);
        chk("reset_cnt", stall_cycles, 0);
        chk("reset_stall", stall, 0);
        chk("reset_prev", {prev, prev_pc}, 0);

        //          instr         pc     rd1      rd2     mwen ld mwreg mres    wwen wwreg wres   v  a        b        imm           wreg wen ld
        vecs[0]  = mk(32'h20010005, 32'h00, 32'h1234, 32'h5555, 0, 0, 0, 0,      0, 0, 0,      1, 32'h0,    32'h5555, 32'h5,        1,  1, 0);
        vecs[1]  = mk(32'h00421820, 32'h04, 32'h10,   32'h10,   1, 0, 2, 32'h99, 0, 0, 0,      1, 32'h99,   32'h99,   32'h1820,     3,  1, 0);
        vecs[2]  = mk(32'h3507FFFF, 32'h08, 32'h0F0F, 32'h1,    0, 0, 0, 0,      1, 7, 32'hBB, 1, 32'h0F0F, 32'hBB,   32'hFFFF,     7,  1, 0);
        vecs[3]  = mk(32'h3C091234, 32'h0C, 32'h11,   32'h22,   0, 0, 0, 0,      0, 0, 0,      1, 32'h0,    32'h22,   32'h12340000, 9,  1, 0);
        vecs[4]  = mk(32'h8D6AFFFC, 32'h10, 32'h1000, 32'h3,    0, 0, 0, 0,      0, 0, 0,      1, 32'h1000, 32'h3,    32'hFFFFFFFC, 10, 1, 1);
        vecs[5]  = mk(32'hADAC0008, 32'h14, 32'h2000, 32'h44,   0, 0, 0, 0,      0, 0, 0,      1, 32'h2000, 32'h44,   32'h8,        0,  0, 0);
        vecs[6]  = mk(32'h0C000100, 32'h18, 32'h5,    32'h6,    0, 0, 0, 0,      0, 0, 0,      1, 32'h0,    32'h0,    32'h100,      31, 1, 0);
        vecs[7]  = mk(32'h20200001, 32'h1C, 32'h7,    32'h8,    0, 0, 0, 0,      0, 0, 0,      1, 32'h7,    32'h0,    32'h1,        0,  0, 0);
        vecs[8]  = mk(32'hFC221234, 32'h20, 32'hA,    32'hB,    0, 0, 0, 0,      0, 0, 0,      1, 32'hA,    32'hB,    32'h1234,     0,  0, 0);
        vecs[9]  = mk(32'h00000000, 32'h24, 32'hC,    32'hD,    0, 0, 0, 0,      0, 0, 0,      0, 32'h0,    32'h0,    32'h0,        0,  0, 0);
        vecs[10] = mk(32'h03E00008, 32'h28, 32'h400,  32'h9,    0, 0, 0, 0,      0, 0, 0,      1, 32'h400,  32'h0,    32'h8,        0,  0, 0);
        vecs[11] = mk(32'h00C62820, 32'h2C, 32'h1,    32'h2,    1, 0, 6, 32'hAA, 1, 6, 32'hBB, 1, 32'hAA,   32'hAA,   32'h2820,     5,  1, 0);
        vecs[12] = mk(32'h00C62820, 32'h2C, 32'h1,    32'h2,    0, 0, 0, 0,      1, 6, 32'hBB, 1, 32'hBB,   32'hBB,   32'h2820,     5,  1, 0);
        vecs[13] = mk(32'h00002820, 32'h30, 32'h3,    32'h4,    1, 0, 0, 32'hAA, 1, 0, 32'hBB, 1, 32'h0,    32'h0,    32'h2820,     5,  1, 0);
        vecs[14] = mk(32'h30418000, 32'h34, 32'h50,   32'h60,   0, 0, 0, 0,      0, 0, 0,      1, 32'h50,   32'h60,   32'h8000,     1,  1, 0);
        vecs[15] = mk(32'h20418000, 32'h38, 32'h50,   32'h60,   0, 0, 0, 0,      0, 0, 0,      1, 32'h50,   32'h60,   32'hFFFF8000, 1,  1, 0);
        vecs[16] = mk(32'h00C62820, 32'h3C, 32'h1,    32'h2,    1, 1, 6, 32'hAA, 1, 6, 32'hBB, 1, 32'hBB,   32'hBB,   32'h2820,     5,  1, 0);

        foreach (vecs[i]) begin
            fe_instr = vecs[i].instr; fe_pc = vecs[i].pc;
            rf_rd1 = vecs[i].rd1; rf_rd2 = vecs[i].rd2;
            mem_wen = vecs[i].mwen; mem_load = vecs[i].mload; mem_wreg = vecs[i].mwreg; mem_result = vecs[i].mres;
            wb_wen = vecs[i].wwen; wb_wreg = vecs[i].wwreg; wb_result = vecs[i].wres;
            sb.push_back(vecs[i].exp);
            step(); step();
            chk($sformatf("vec%0d_bundle", i), act_bun(), sb.pop_front());
            chk($sformatf("vec%0d_stall", i), stall, 0);
            chk($sformatf("vec%0d_prev", i), {prev, prev_pc}, {vecs[i].instr, vecs[i].pc});
        end

        // Load-use: lw $2 in EX, add $3,$2,$2 in ID.
        clr();
        fe_instr = 32'h00421820; fe_pc = 32'h40;
        step();
        ex_wen = 1; ex_load = 1; ex_wreg = 2; fe_instr = 32'h20010005; fe_pc = 32'h44;
        #1;
        chk("lu_stall", stall, 1);
        chk("lu_prev", {prev, prev_pc}, {32'h0, 32'h40});
        step(); cnt_inc();
        chk("lu_bubble", {id_valid, id_instr, id_wen, id_wreg, id_load}, 0);
        chk("lu_cnt", stall_cycles, exp_cnt);
        ex_wen = 0; ex_load = 0; ex_wreg = 0;
        mem_wen = 1; mem_load = 1; mem_wreg = 2; wb_wen = 1; wb_wreg = 2; wb_result = 32'h77;
        #1;
        chk("lu_release", {stall, prev}, {1'b0, 32'h00421820});
        step();
        chk("lu_fwd", {id_valid, id_a, id_b, id_wreg, id_wen}, {1'b1, 32'h77, 32'h77, 5'd3, 1'b1});
        chk("lu_next", prev_pc, 32'h44);

        // Branch on EX load: two stall cycles, then operands from WB.
        clr();
        fe_instr = 32'h10850003; fe_pc = 32'h80;
        step();
        ex_wen = 1; ex_load = 0; ex_wreg = 5;
        #1;
        chk("br_ex_alu", stall, 1);
        ex_load = 1; ex_wreg = 4;
        #1;
        chk("br_s1", {stall, prev}, {1'b1, 32'h0});
        step(); cnt_inc();
        ex_wen = 0; ex_load = 0; ex_wreg = 0; mem_wen = 1; mem_load = 1; mem_wreg = 4;
        #1;
        chk("br_s2", {stall, prev}, {1'b1, 32'h0});
        step(); cnt_inc();
        chk("br_cnt", stall_cycles, exp_cnt);
        mem_wen = 0; mem_load = 0; mem_wreg = 0; wb_wen = 1; wb_wreg = 4; wb_result = 9; rf_rd2 = 9;
        #1;
        chk("br_res", {stall, eq, vs, prev, prev_pc}, {1'b0, 1'b1, 32'h9, 32'h10850003, 32'h80});
        chk("br_bubble", id_valid, 0);

        // ex_hold with a hazard pending freezes everything.
        fe_instr = 32'h00421820; fe_pc = 32'hC0;
        beq_bun = {1'b1, 32'h80, 32'h10850003, 32'h9, 32'h9, 32'h3, 5'd0, 1'b0, 1'b0};
        step();
        chk("hold_pre", act_bun(), beq_bun);
        clr();
        ex_hold = 1; ex_wen = 1; ex_load = 1; ex_wreg = 2; fe_instr = 32'h20010005; fe_pc = 32'hC4;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold%0d_stall", k), stall, 0);
            step();
            chk($sformatf("hold%0d_bundle", k), act_bun(), beq_bun);
            chk($sformatf("hold%0d_ifid", k), {prev_pc, stall_cycles}, {32'hC0, exp_cnt});
        end
        ex_hold = 0;
        #1;
        chk("hold_rel", stall, 1);

        // Reset while hazard-stalled.
        reset = 1;
        step();
        reset = 0; exp_cnt = 0;
        chk("rst_bundle", act_bun(), 168'h0);
        chk("rst_out", {stall, prev, prev_pc, stall_cycles}, 0);
        chk("rst_state", int'(dut.r_state), 0);

        // Saturation of the 4-bit counter.
        clr();
        fe_instr = 32'h00421820; fe_pc = 32'h100;
        step();
        ex_wen = 1; ex_load = 1; ex_wreg = 2;
        repeat (14) begin step(); cnt_inc(); end
        chk("sat_14", stall_cycles, 4'hE);
        repeat (3) begin step(); cnt_inc(); end
        chk("sat_max", stall_cycles, exp_cnt);
        chk("sat_stall", stall, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- IF/ID pipeline register plus decode stage of the 5-stage MIPS pipeline; sits directly downstream of the fetch frontend.
- Latches pc/instr from fetch, reads the register file, and forwards from MEM/WB.
- Detects data hazards and stalls fetch; resolves branch operands (eq, vs, prev, prev_pc) back to fetch.
- Issues a decoded bundle to EX with a valid flag.

Parameters:
- STALL_CNT_W, 32, width of the saturating hazard-stall performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- fe_pc  in  32  pc from fetch
- fe_instr  in  32  instruction from fetch; 0 = nop
- ex_hold  in  1  EX backpressure; freezes this stage entirely
- stall  out  1  to fetch; holds fetch this cycle
- eq  out  1  forwarded rs value == forwarded rt value
- vs  out  32  forwarded rs value (jr target)
- prev  out  32  instruction currently in ID; 0 while hazard-stalled
- prev_pc  out  32  pc of instruction in ID
- rf_ra1, rf_ra2  out  5  regfile read addresses (rs, rt)
- rf_rd1, rf_rd2  in  32  combinational regfile read data
- ex_wen, ex_load  in  1  EX instr writes a reg / is lw
- ex_wreg  in  5  EX destination
- mem_wen, mem_load  in  1  MEM instr writes a reg / is lw
- mem_wreg  in  5  MEM destination
- mem_result  in  32  MEM ALU result; not valid when mem_load
- wb_wen  in  1  WB write enable
- wb_wreg  in  5  WB destination
- wb_result  in  32  WB write data
- id_valid  out  1  bundle to EX is a real instruction
- id_pc, id_instr  out  32  registered to EX
- id_a, id_b  out  32  forwarded rs/rt values
- id_imm  out  32  extended immediate
- id_wreg  out  5  destination (0 = none)
- id_wen, id_load  out  1  write-enable / is lw
- stall_cycles  out  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset: IF/ID register pc=0, instr=0; EX bundle registers all 0 (id_valid=0); stall_cycles=0; state RUN.
- IF/ID capture on posedge when !stall && !ex_hold. On stall, or on ex_hold without stall, the register holds.
- Decode is combinational from the IF/ID register:
  - R-type (op 0): reads rs, rt; writes rd; jr (funct 0x08) reads rs only, no write.
  - addi/addiu/slti/andi/ori (0x08/09/0a/0c/0d): read rs, write rt.
  - lui 0x0f: writes rt, no reads.
  - lw 0x23: reads rs, writes rt, load=1.
  - sw 0x2b, beq 0x04, bne 0x05: read rs, rt; no write.
  - j 0x02: no reads/writes.
  - jal 0x03: writes 31.
  - Unknown opcodes are treated as nop.
  - A write to reg 0 forces wen=0 and wreg=0.
- Immediate extension: zero-extend for andi/ori; lui gives imm<<16; otherwise sign-extend.
- Forwarding per source, in priority order:
  - reg 0 → 0;
  - MEM match with mem_wen && !mem_load → mem_result;
  - WB match with wb_wen → wb_result;
  - else regfile data.
- Hazard, raw = any of the following:
  - any read source matches ex_wreg with ex_wen && ex_load;
  - branch/jr (beq, bne, jr) source matches ex_wreg with ex_wen (any EX write);
  - branch/jr source matches mem_wreg with mem_wen && mem_load.
- stall = hazard && !ex_hold.
- FSM states:
  - RUN: no hazard.
  - HAZ: entered on a cycle with hazard; stays while hazard persists. A branch dependent on an EX load spends 2 cycles in HAZ.
  - The state is registered for observability only; outputs derive from the current hazard.
- EX bundle update on posedge when !ex_hold:
  - hazard → bubble: id_valid=0, id_instr=0, id_wen=0, id_wreg=0, id_load=0.
  - otherwise → decoded values, with id_valid=1 iff instr != 0.
  - ex_hold → all EX bundle registers hold.
- prev = hazard ? 0 : IF/ID instr. prev_pc = IF/ID pc. eq and vs are always driven from forwarded values.
- stall_cycles increments on each posedge with stall=1 and saturates at all-ones.
- Reset mid-stall clears state to RUN, the IF/ID register to nop, and the counter to 0.

Test Plan:
- Reset, then fe_instr=addi $1,$0,5 (0x20010005), pc=0x0 → next cycle id_valid=1, id_wreg=1, id_imm=5, id_a=0, stall=0.
- EX lw $2 (ex_wen=1, ex_load=1, ex_wreg=2), ID add $3,$2,$2 → stall=1 for one cycle, bubble to EX, stall_cycles=1. Then with mem_load=1, wb_wen, wb_result=0x77 → id_a=id_b=0x77.
- ID beq $4,$5; EX lw $4 → stall 2 cycles (EX-load rule, then MEM-load rule), prev=0 during both. Then wb_result=9 and rf_rd2=9 → eq=1, prev=beq word.
- MEM writes $6=0xAA, WB writes $6=0xBB, ID reads $6 → id_a=0xAA (MEM priority). With only WB → 0xBB. Reading $0 with any forwarding → 0.
- ex_hold=1 for 3 cycles with a hazard present → stall=0, EX bundle and IF/ID frozen, stall_cycles unchanged.
- Reset asserted mid-HAZ → all outputs 0, state RUN, stall_cycles=0. Saturation: force counter to all-ones minus 1, stall 3 cycles → holds all-ones.
